// File: rtl/glift_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, with a shadow taint
// bit on every data bit propagated by conservative information-flow rules.
module glift_seq_divider #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dvd,
    input  logic [DVD_W-1:0] dvd_t,
    input  logic [DVS_W-1:0] dvs,
    input  logic [DVS_W-1:0] dvs_t,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] q,
    output logic [DVD_W-1:0] q_t,
    output logic [DVS_W-1:0] r,
    output logic [DVS_W-1:0] r_t,
    output logic             dz,
    output logic             dz_t
);
    localparam int IW = (DVD_W > 1) ? $clog2(DVD_W) : 1;

    // Handshake: start is sampled only while busy=0 (IDLE or DONE). An accepted
    // start raises busy at that edge; done pulses for exactly one cycle once the
    // last quotient bit is produced, and results hold until the next completion.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [DVD_W-1:0] dvd_l, dvd_tl;
    logic [DVS_W-1:0] dvs_l, dvs_tl;
    // After each compare the partial remainder is below dvs, so only the
    // shifted value S needs the extra bit.
    logic [DVS_W-1:0] rem, rem_t;
    logic [IW-1:0]    idx;
    logic [DVD_W-1:0] q_acc, qt_acc;

    logic [DVS_W:0]   s, st, dvs_ext;
    logic [DVS_W-1:0] rem_nxt;
    logic             qbit, c_t;
    logic [DVD_W-1:0] q_nxt, qt_nxt;
    logic             dz_nxt, dzt_nxt;

    always_comb begin
        s       = {rem, dvd_l[idx]};
        st      = {rem_t, dvd_tl[idx]};
        dvs_ext = {1'b0, dvs_l};
        qbit    = (s >= dvs_ext);
        rem_nxt = qbit ? DVS_W'(s - dvs_ext) : s[DVS_W-1:0];
        // Any tainted bit in either compare operand taints the decision.
        c_t     = (|st) | (|dvs_tl);
        q_nxt   = q_acc;
        qt_nxt  = qt_acc;
        q_nxt[idx]  = qbit;
        qt_nxt[idx] = c_t;
        dz_nxt  = (dvs_l == '0);
        dzt_nxt = |dvs_tl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            q      <= '0;
            q_t    <= '0;
            r      <= '0;
            r_t    <= '0;
            dz     <= 1'b0;
            dz_t   <= 1'b0;
            dvd_l  <= '0;
            dvd_tl <= '0;
            dvs_l  <= '0;
            dvs_tl <= '0;
            rem    <= '0;
            rem_t  <= '0;
            idx    <= '0;
            q_acc  <= '0;
            qt_acc <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_l  <= dvd;
                        dvd_tl <= dvd_t;
                        dvs_l  <= dvs;
                        dvs_tl <= dvs_t;
                        rem    <= '0;
                        rem_t  <= '0;
                        idx    <= IW'(DVD_W - 1);
                        q_acc  <= '0;
                        qt_acc <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    rem    <= rem_nxt;
                    rem_t  <= {DVS_W{c_t}};
                    q_acc  <= q_nxt;
                    qt_acc <= qt_nxt;
                    idx    <= idx - IW'(1);
                    if (idx == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                        dz    <= dz_nxt;
                        dz_t  <= dzt_nxt;
                        if (dz_nxt) begin
                            q   <= '1;
                            q_t <= {DVD_W{dzt_nxt}};
                            r   <= dvd_l[DVS_W-1:0];
                            r_t <= dvd_tl[DVS_W-1:0] | {DVS_W{dzt_nxt}};
                        end else begin
                            q   <= q_nxt;
                            q_t <= qt_nxt;
                            r   <= rem_nxt;
                            r_t <= {DVS_W{c_t}};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
